// File: rtl/insn_fetch_pkg.sv
// Shared fetch-stage definitions: instruction/memory widths, memory bound,
// reset PC and the depth of the decode-side skid buffer.
package insn_fetch_pkg;

   localparam int LEN_REG         = 32;
   localparam int MEM_INSN_ADDR   = 8;
   localparam int MEM_INSN_LEN    = 200;

   localparam int FETCH_RESET_PC  = 0;
   localparam int FETCH_BUF_DEPTH = 2;
   localparam int FETCH_CNT_W     = $clog2(FETCH_BUF_DEPTH + 1);
   localparam int FETCH_PTR_W     = $clog2(FETCH_BUF_DEPTH);

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small skid buffer between the instruction memory and decode. The head entry is
// always visible on head_data; flush empties it in one cycle and beats push/pop.
module fetch_skid_fifo
   import insn_fetch_pkg::*;
#(
   parameter int WIDTH = 40
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       head_data,
   output logic [FETCH_CNT_W-1:0] count
);

   logic [WIDTH-1:0]       entries [FETCH_BUF_DEPTH];
   logic [FETCH_PTR_W-1:0] rd_ptr;
   logic [FETCH_PTR_W-1:0] wr_ptr;

   function automatic logic [FETCH_PTR_W-1:0] ptr_next(input logic [FETCH_PTR_W-1:0] p);
      return (p == FETCH_PTR_W'(FETCH_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage needs no reset: count alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         entries[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_data = entries[rd_ptr];

endmodule

// File: rtl/insn_fetch.sv
// PC and fetch stage in front of a synchronous instruction memory, feeding decode
// through a 2-entry skid buffer. FETCH_BOUND_EN enables the out-of-range fetch fault.
module insn_fetch #(
   parameter int                  MEM_ADDR = insn_fetch_pkg::MEM_INSN_ADDR,
   parameter int                  MEM_LEN  = insn_fetch_pkg::MEM_INSN_LEN,
   parameter int                  LEN_REG  = insn_fetch_pkg::LEN_REG,
   parameter logic [MEM_ADDR-1:0] RESET_PC = MEM_ADDR'(insn_fetch_pkg::FETCH_RESET_PC)
) (
   input  logic                clk,
   input  logic                rst,
   output logic [MEM_ADDR-1:0] mem_a,
   input  logic [LEN_REG-1:0]  mem_q,
   input  logic                redir_valid,
   input  logic [MEM_ADDR-1:0] redir_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LEN_REG-1:0]  out_insn,
   output logic [MEM_ADDR-1:0] out_pc,
   output logic                fetch_fault
);
   import insn_fetch_pkg::*;

   localparam int ENTRY_W = LEN_REG + MEM_ADDR;

`ifdef FETCH_BOUND_EN
   localparam bit BOUND_EN = 1'b1;
`else
   localparam bit BOUND_EN = 1'b0;
`endif

   logic [MEM_ADDR-1:0]    pc;
   logic [MEM_ADDR-1:0]    inflight_pc;
   logic                   inflight;
   logic                   fault;
   logic [FETCH_CNT_W-1:0] count;
   logic [ENTRY_W-1:0]     head;
   logic                   pop;
   logic                   issue;
   logic                   has_credit;
   logic                   pc_oob;
   logic                   target_oob;

   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;

   // Reserve a slot for every read in flight so a returning word always has room.
   assign has_credit = (int'(count) + int'(inflight) - int'(pop)) < FETCH_BUF_DEPTH;
   assign pc_oob     = BOUND_EN && (int'(pc) > MEM_LEN);
   assign target_oob = BOUND_EN && (int'(redir_pc) > MEM_LEN);
   assign issue      = !redir_valid && has_credit && !pc_oob;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= RESET_PC;
         fault       <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= pc;
         end
         if (redir_valid) begin
            pc <= redir_pc;
         end else if (issue) begin
            pc <= pc + 1'b1;
         end
         if (redir_valid) begin
            fault <= target_oob;
         end else if (pc_oob) begin
            fault <= 1'b1;
         end
      end
   end

   // A redirect flushes the buffer, which also drops the word returning this cycle.
   fetch_skid_fifo #(
      .WIDTH(ENTRY_W)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .push     (inflight),
      .push_data({mem_q, inflight_pc}),
      .pop      (pop),
      .flush    (redir_valid),
      .head_data(head),
      .count    (count)
   );

   assign mem_a       = pc;
   assign out_insn    = head[ENTRY_W-1:MEM_ADDR];
   assign out_pc      = head[MEM_ADDR-1:0];
   assign fetch_fault = fault;

endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: the expected instruction stream is sequential PCs from the last
// reset or redirect target; a monitor pops and compares every accepted output.
module tb_insn_fetch;
   import insn_fetch_pkg::*;

   localparam int AW      = MEM_INSN_ADDR;
   localparam int DW      = LEN_REG;
   localparam int PC_SPAN = 1 << AW;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] insn;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_q;
   logic          redir_valid;
   logic [AW-1:0] redir_pc;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_insn;
   logic [AW-1:0] out_pc;
   logic          fetch_fault;

   logic [DW-1:0] mem [PC_SPAN];

   exp_t exp_q[$];
   int   gen_pc      = FETCH_RESET_PC;
   int   checks      = 0;
   int   failures    = 0;
   int   idle_cycles = 0;

   insn_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .mem_a      (mem_a),
      .mem_q      (mem_q),
      .redir_valid(redir_valid),
      .redir_pc   (redir_pc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_insn   (out_insn),
      .out_pc     (out_pc),
      .fetch_fault(fetch_fault)
   );

   initial forever #5 clk = ~clk;

   initial begin
      for (int i = 0; i < PC_SPAN; i++) begin
         mem[i] = DW'(32'h100 + i);
      end
   end

   always @(posedge clk) mem_q <= mem[mem_a];

   function automatic logic [DW-1:0] insnFor(input int pc);
      return DW'(32'h100 + pc);
   endfunction

   function automatic bit fetchable(input int pc);
`ifdef FETCH_BOUND_EN
      return pc <= MEM_INSN_LEN;
`else
      return pc >= 0;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   task automatic flushModel(input int target);
      exp_q.delete();
      gen_pc = target;
   endtask

   // Keep a few expected entries ahead of the DUT; at most one is consumed per cycle.
   always @(posedge clk) begin
      while (exp_q.size() < 4 && fetchable(gen_pc)) begin
         exp_q.push_back('{pc: AW'(gen_pc), insn: insnFor(gen_pc)});
         gen_pc = (gen_pc + 1) % PC_SPAN;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst || redir_valid) begin
         idle_cycles = 0;
      end
      if (!rst && out_valid && out_ready) begin
         idle_cycles = 0;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_unexpected: got pc 0x%0h insn 0x%0h, expected no output", out_pc, out_insn);
         end else begin
            e = exp_q.pop_front();
            checkOutput("sb_pc", 64'(out_pc), 64'(e.pc));
            checkOutput("sb_insn", 64'(out_insn), 64'(e.insn));
         end
      end else if (!rst && !redir_valid && out_ready && exp_q.size() != 0) begin
         idle_cycles++;
         if (idle_cycles > 8) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_timeout: no output for %0d ready cycles, expected pc 0x%0h", idle_cycles, exp_q[0].pc);
            idle_cycles = 0;
         end
      end
   end

   task automatic applyReset();
      @(posedge clk); #1;
      rst         = 1'b1;
      out_ready   = 1'b0;
      redir_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_mem_a", 64'(mem_a), 64'(FETCH_RESET_PC));
      checkOutput("rst_fault", 64'(fetch_fault), 64'(0));
      #1 flushModel(FETCH_RESET_PC);
   endtask

   task automatic applyRedirect(input int target, input logic ready_in);
      @(posedge clk); #1;
      redir_valid = 1'b1;
      redir_pc    = AW'(target);
      out_ready   = ready_in;
      @(negedge clk); #1;
      flushModel(target);
      @(posedge clk); #1;
      redir_valid = 1'b0;
      out_ready   = 1'b1;
      @(negedge clk);
      checkOutput("redir_r1_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
      checkOutput("redir_r2_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
      checkOutput("redir_r3_valid", 64'(out_valid), 64'(1));
      checkOutput("redir_r3_pc", 64'(out_pc), 64'(target));
   endtask

   task automatic applyStimulus(input int n_cycles);
      for (int i = 0; i < n_cycles; i++) begin
         @(posedge clk); #1;
         rst         = ($urandom_range(0, 149) == 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         redir_valid = ($urandom_range(0, 15) == 0);
`ifdef FETCH_BOUND_EN
         redir_pc    = AW'($urandom_range(0, MEM_INSN_LEN));
`else
         redir_pc    = AW'($urandom_range(0, PC_SPAN - 1));
`endif
         @(negedge clk); #1;
         if (rst) begin
            flushModel(FETCH_RESET_PC);
         end else if (redir_valid) begin
            flushModel(int'(redir_pc));
         end
      end
   endtask

   initial begin
      rst         = 1'b1;
      out_ready   = 1'b0;
      redir_valid = 1'b0;
      redir_pc    = '0;

      // Streaming from reset: first output two cycles after release.
      applyReset();
      @(posedge clk); #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("lat_c0_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
      checkOutput("lat_c1_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
      checkOutput("lat_c2_valid", 64'(out_valid), 64'(1));
      checkOutput("lat_c2_pc", 64'(out_pc), 64'(0));
      repeat (10) @(negedge clk);

      // Mid-run reset, then decode stalls: buffer fills with pc 0,1 and holds.
      applyReset();
      @(posedge clk); #1;
      rst       = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stall_valid", 64'(out_valid), 64'(1));
         checkOutput("stall_pc", 64'(out_pc), 64'(0));
         checkOutput("stall_insn", 64'(out_insn), 64'(32'h100));
         checkOutput("stall_mem_a", 64'(mem_a), 64'(2));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (8) @(negedge clk);

      // Redirect while streaming (read in flight, pop in the same cycle).
      applyRedirect(32'h40, 1'b1);
      repeat (6) @(negedge clk);

      // Redirect while stalled with a full buffer.
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (4) @(negedge clk);
      applyRedirect(32'h20, 1'b0);
      repeat (6) @(negedge clk);

`ifdef FETCH_BOUND_EN
      applyRedirect(MEM_INSN_LEN - 2, 1'b1);
      repeat (10) @(negedge clk);
      checkOutput("bound_fault", 64'(fetch_fault), 64'(1));
      checkOutput("bound_drained", 64'(out_valid), 64'(0));
      applyRedirect(0, 1'b1);
      checkOutput("bound_cleared", 64'(fetch_fault), 64'(0));
`else
      applyRedirect(PC_SPAN - 2, 1'b1);
      repeat (6) @(negedge clk);
      checkOutput("wrap_fault", 64'(fetch_fault), 64'(0));
`endif

      applyStimulus(400);

      @(posedge clk); #1;
      rst         = 1'b0;
      redir_valid = 1'b0;
      out_ready   = 1'b1;
      repeat (12) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
